// File: rtl/adder_sched_pkg.sv
// Shared constants and helpers for the round-robin adder scheduler.
package adder_sched_pkg;

  localparam int unsigned DEF_N_REQ  = 4;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  // Requester id width: clog2 with a floor of one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Index following idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the slot after the last winner.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              enable,
  input  logic              accept,
  output logic [N_REQ-1:0]  grant_c,
  output logic [ID_W-1:0]   grant_idx_c
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  int unsigned     start_c;
  logic            found_c;

  // Two passes: indices at or above the start slot first, then the wrapped-around ones.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found_c     = 1'b0;
    start_c     = rr_next(32'(ptr_q), N_REQ);
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (enable && !found_c && req[i] && (i >= start_c)) begin
        found_c     = 1'b1;
        grant_c[i]  = 1'b1;
        grant_idx_c = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (enable && !found_c && req[i] && (i < start_c)) begin
        found_c     = 1'b1;
        grant_c[i]  = 1'b1;
        grant_idx_c = ID_W'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = grant_idx_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= ID_W'(N_REQ - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one registered adder among N_REQ requesters; returns tagged sums one cycle after accept.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ID_W   = id_width(N_REQ),
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_a,
  input  logic [N_REQ*DATA_W-1:0]  req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_sum,
  output logic                     rsp_cout,
  output logic [CNT_W-1:0]         txn_count
);

  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic [CNT_W-1:0]  txn_count_q, txn_count_d;

  logic              slot_free_c;
  logic              accept_c;
  logic [N_REQ-1:0]  grant_c;
  logic [ID_W-1:0]   grant_idx_c;
  logic [DATA_W-1:0] sel_a_c, sel_b_c;
  logic [DATA_W:0]   sum_c;

  assign slot_free_c = !rsp_valid_q || rsp_ready;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_valid),
    .enable      (slot_free_c),
    .accept      (accept_c),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  // Grants are suppressed while reset is asserted so nothing is handed out mid-reset.
  assign req_ready = grant_c & {N_REQ{rst_n}};
  assign accept_c  = |req_ready;

  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) begin
        sel_a_c = req_a[i*DATA_W +: DATA_W];
        sel_b_c = req_b[i*DATA_W +: DATA_W];
      end
    end
    sum_c = {1'b0, sel_a_c} + {1'b0, sel_b_c};
  end

  // A new accept overwrites the slot; a drain alone only clears valid.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    txn_count_d = txn_count_q + CNT_W'(rsp_valid_q && rsp_ready);
    if (accept_c) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx_c;
      rsp_sum_d   = sum_c[DATA_W-1:0];
      rsp_cout_d  = sum_c[DATA_W];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      txn_count_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_adder_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_sum;
  logic            rsp_cout;
  logic [CW-1:0]   txn_count;

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_ptr;
  bit          m_valid;
  int          m_id;
  logic [DW-1:0] m_sum;
  logic        m_cout;
  logic [CW-1:0] m_cnt;

  adder_rr_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] g;
    int idx;
    g = '0;
    if (rst_n !== 1'b1) return g;
    if (m_valid && !rsp_ready) return g;
    for (int k = 1; k <= N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic reset_model();
    m_ptr = N - 1; m_valid = 0; m_id = 0; m_sum = '0; m_cout = 1'b0; m_cnt = '0;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic cycle();
    logic [N-1:0] g;
    logic [DW:0]  s;
    int gi;
    g = exp_ready();
    @(posedge clk);
    if (m_valid && rsp_ready) m_cnt = m_cnt + 1'b1;
    if (g != '0) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (g[i]) gi = i;
      s = {1'b0, req_a[gi*DW +: DW]} + {1'b0, req_b[gi*DW +: DW]};
      m_valid = 1; m_id = gi; m_sum = s[DW-1:0]; m_cout = s[DW]; m_ptr = gi;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
    req_a = '0; req_b = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #3;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL reset_txn_count got %0d want 0", txn_count); end
    checks++; if (rsp_sum !== 8'h00 || rsp_id !== 2'd0 || rsp_cout !== 1'b0) begin
      errors++; $display("FAIL reset_fields got id=%0d sum=%h cout=%b want 0/00/0", rsp_id, rsp_sum, rsp_cout); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", req_ready); end
    cycle();
    req_valid = '0;
    cycle();
  endtask

  task automatic test_single();
    req_valid = 4'b0100; rsp_ready = 1'b1;
    set_req(2, 8'h05, 8'h03);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    cycle();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 8'h08 || rsp_cout !== 1'b0) begin
      errors++; $display("FAIL single_rsp got v=%b id=%0d sum=%h c=%b want 1/2/08/0", rsp_valid, rsp_id, rsp_sum, rsp_cout); end
    cycle();
  endtask

  task automatic test_carry();
    logic [DW-1:0] av [2];
    logic [DW-1:0] bv [2];
    logic [DW-1:0] sv [2];
    av[0] = 8'hFF; bv[0] = 8'h01; sv[0] = 8'h00;
    av[1] = 8'hFF; bv[1] = 8'hFF; sv[1] = 8'hFE;
    rsp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      req_valid = 4'b0001;
      set_req(0, av[t], bv[t]);
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL carry_ready%0d got %b want 0001", t, req_ready); end
      cycle();
      req_valid = '0;
      #1;
      checks++; if (rsp_id !== 2'd0 || rsp_sum !== sv[t] || rsp_cout !== 1'b1) begin
        errors++; $display("FAIL carry_rsp%0d got id=%0d sum=%h c=%b want 0/%h/1", t, rsp_id, rsp_sum, rsp_cout, sv[t]); end
      cycle();
    end
  endtask

  task automatic test_fairness();
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    set_req(3, 8'h10, 8'h20);
    cycle();
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom));
      #1;
      checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL fair_ready%0d got %b want %b", k, req_ready, exp_ready()); end
      cycle();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(k % N)) begin
        errors++; $display("FAIL fair_id%0d got v=%b id=%0d want 1/%0d", k, rsp_valid, rsp_id, k % N); end
      checks++; if (rsp_sum !== m_sum || rsp_cout !== m_cout) begin
        errors++; $display("FAIL fair_sum%0d got %b_%h want %b_%h", k, rsp_cout, rsp_sum, m_cout, m_sum); end
      checks++; if (txn_count !== m_cnt) begin errors++; $display("FAIL fair_count%0d got %0d want %0d", k, txn_count, m_cnt); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] hold_sum;
    logic          hold_cout;
    int            hold_id;
    int            nxt;
    hold_sum = m_sum; hold_cout = m_cout; hold_id = m_id;
    rsp_ready = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d got %b want 0000", k, req_ready); end
      cycle();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(hold_id) || rsp_sum !== hold_sum || rsp_cout !== hold_cout) begin
        errors++; $display("FAIL bp_hold%0d got v=%b id=%0d sum=%h c=%b want 1/%0d/%h/%b",
                           k, rsp_valid, rsp_id, rsp_sum, rsp_cout, hold_id, hold_sum, hold_cout); end
    end
    rsp_ready = 1'b1;
    nxt = (hold_id + 1) % N;
    #1;
    checks++; if (req_ready !== N'(1 << nxt)) begin errors++; $display("FAIL bp_release_ready got %b want %b", req_ready, N'(1 << nxt)); end
    cycle();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(nxt) || rsp_sum !== m_sum) begin
      errors++; $display("FAIL bp_release_rsp got v=%b id=%0d sum=%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_sum, nxt, m_sum); end
  endtask

  task automatic test_async_reset();
    req_valid = 4'b1111; rsp_ready = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || txn_count !== 16'd0) begin
      errors++; $display("FAIL areset_clear got v=%b rdy=%b cnt=%0d want 0/0000/0", rsp_valid, req_ready, txn_count); end
    @(negedge clk);
    #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL areset_first_grant got %b want 0001", req_ready); end
    cycle();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL areset_first_rsp got v=%b id=%0d want 1/0", rsp_valid, rsp_id); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom));
      #1;
      checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready%0d got %b want %b", k, req_ready, exp_ready()); end
      cycle();
      checks++; if (rsp_valid !== m_valid || txn_count !== m_cnt) begin
        errors++; $display("FAIL rand_state%0d got v=%b cnt=%0d want %b/%0d", k, rsp_valid, txn_count, m_valid, m_cnt); end
      if (m_valid) begin
        checks++; if (rsp_id !== IW'(m_id) || rsp_sum !== m_sum || rsp_cout !== m_cout) begin
          errors++; $display("FAIL rand_rsp%0d got id=%0d sum=%h c=%b want %0d/%h/%b", k, rsp_id, rsp_sum, rsp_cout, m_id, m_sum, m_cout); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_fairness();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
